// File: rtl/cen_seq_gen_pkg.sv
// Shared types and constants for the cen_seq_gen stimulus generator.
package cen_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } cen_seq_state_t;

  typedef enum logic [1:0] {
    MODE_ALL_ON    = 2'd0,
    MODE_WALK_ONE  = 2'd1,
    MODE_WALK_ZERO = 2'd2,
    MODE_LFSR      = 2'd3
  } cen_seq_mode_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/cen_seq_gen_if.sv
// Control/status bundle between a sequencer controller and cen_seq_gen.
interface cen_seq_gen_if #(
  parameter int unsigned LANES  = 32,
  parameter int unsigned HOLD_W = 20
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [HOLD_W-1:0] hold_cycles;
  logic [7:0]        num_patterns;
  logic [LANES-1:0]  cen;
  logic              busy;
  logic              done;
  logic [7:0]        pat_idx;

  modport master (
    output start, stop, mode, hold_cycles, num_patterns,
    input  cen, busy, done, pat_idx
  );

  modport slave (
    input  start, stop, mode, hold_cycles, num_patterns,
    output cen, busy, done, pat_idx
  );
endinterface

// File: rtl/cen_seq_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous load of a parameter seed and single-step advance.
module cen_seq_lfsr
  import cen_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o,
  output logic [31:0] next_o
);

  // An all-zero state would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q, lfsr_d;

  assign next_o  = lfsr_advance(lfsr_q);
  assign state_o = lfsr_q;

  // Load takes priority over step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = SEED_EFF;
    else if (step_i) lfsr_d = next_o;
  end

  // LFSR state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED_EFF;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/cen_seq_gen.sv
// Lane-enable pattern sequencer for the parallel enable-counter array.
// Optional hit counter enabled by defining CEN_SEQ_HIT_CHECK_EN.
module cen_seq_gen
  import cen_seq_pkg::*;
#(
  parameter int unsigned LANES      = 32,
  parameter int unsigned HOLD_W     = 20,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic          clock,
  input  logic          reset,
  cen_seq_gen_if.slave  bus
`ifdef CEN_SEQ_HIT_CHECK_EN
  ,
  input  logic          cout_in,
  output logic [7:0]    hit_cnt
`endif
);

  localparam int unsigned       GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  cen_seq_state_t    state_q, state_d;
  cen_seq_mode_t     mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        pat_idx_q, pat_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LANES-1:0]  cen_q, cen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              lfsr_load, lfsr_step;
  logic [31:0]       lfsr_cur, lfsr_nxt;
  logic [HOLD_W-1:0] hold_last;
  logic [7:0]        pat_last;
  logic              abort;
  logic              gap_end;

  function automatic logic [LANES-1:0] pattern(input cen_seq_mode_t m,
                                               input logic [7:0]    idx,
                                               input logic [31:0]   lf);
    logic [LANES-1:0] one;
    one = LANES'(1) << (32'(idx) % LANES);
    case (m)
      MODE_ALL_ON:    pattern = '1;
      MODE_WALK_ONE:  pattern = one;
      MODE_WALK_ZERO: pattern = ~one;
      default:        pattern = lf[LANES-1:0];
    endcase
  endfunction

  cen_seq_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .state_o (lfsr_cur),
    .next_o  (lfsr_nxt)
  );

  // hold_cycles of 0 behaves as 1; num_patterns of 0 wraps to a last index of 255.
  assign hold_last = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
  assign pat_last  = num_q - 8'd1;
  assign abort     = bus.stop && (state_q != ST_IDLE);
  assign gap_end   = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);

  // Next-state and registered-output logic; cen is computed one cycle ahead
  // so it lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    hold_d     = hold_q;
    num_d      = num_q;
    pat_idx_d  = pat_idx_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cen_d      = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d   = ST_LOAD;
          mode_d    = cen_seq_mode_t'(bus.mode);
          hold_d    = bus.hold_cycles;
          num_d     = bus.num_patterns;
          pat_idx_d = '0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        cen_d      = pattern(mode_q, pat_idx_q, lfsr_cur);
      end
      ST_HOLD: begin
        if (hold_cnt_q == hold_last) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          cen_d      = pattern(mode_q, pat_idx_q, lfsr_cur);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (pat_idx_q == pat_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = ST_HOLD;
            pat_idx_d  = pat_idx_q + 8'd1;
            lfsr_step  = 1'b1;
            hold_cnt_d = '0;
            // Next pattern uses the stepped LFSR value, visible only next cycle.
            cen_d      = pattern(mode_q, pat_idx_q + 8'd1, lfsr_nxt);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      cen_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pat_idx_d = pat_idx_q;
      lfsr_step = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ALL_ON;
      hold_q     <= '0;
      num_q      <= '0;
      pat_idx_q  <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      cen_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      num_q      <= num_d;
      pat_idx_q  <= pat_idx_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cen_q      <= cen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.cen     = cen_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pat_idx = pat_idx_q;

`ifdef CEN_SEQ_HIT_CHECK_EN
  logic       hit_seen_q, hit_seen_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;

  // Track whether cout_in was high during the current pattern window (HOLD..GAP end).
  always_comb begin
    hit_seen_d = hit_seen_q;
    hit_cnt_d  = hit_cnt_q;
    if (state_q == ST_LOAD) begin
      hit_seen_d = 1'b0;
      hit_cnt_d  = '0;
    end else if (abort || state_q == ST_IDLE || state_q == ST_DONE) begin
      hit_seen_d = 1'b0;
    end else if (gap_end) begin
      hit_seen_d = 1'b0;
      if ((hit_seen_q || cout_in) && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
    end else if (cout_in) begin
      hit_seen_d = 1'b1;
    end
  end

  // Hit tracking registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_seen_q <= 1'b0;
      hit_cnt_q  <= '0;
    end else begin
      hit_seen_q <= hit_seen_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule
